// File: rtl/fifo_wr_arbiter.sv
// Round-robin, per-burst owner of the FIFO write port; grant registered (1-cycle arbitration latency).
// Backpressure: owner ready = ~fifo_full_i combinationally, stalled beats keep the grant.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                          wr_clk,
    input  logic                          reset_n,
    input  logic                          arb_en_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic [7:0]                    beat_cnt_o
);
    localparam int                 PTR_W     = $clog2(NUM_REQ);
    localparam logic [0:0]         ST_IDLE   = 1'b0;
    localparam logic [0:0]         ST_BURST  = 1'b1;
    localparam logic [7:0]         LAST_CNT  = 8'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0]   PTR_RST   = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]     NREQ_W    = (PTR_W+1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] GRANT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [0:0]            state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;

    logic                  pick_vld;
    logic [PTR_W-1:0]      pick_idx;
    logic [PTR_W:0]        cand;
    logic                  owner_vld;
    logic                  owner_last;
    logic [DATA_WIDTH-1:0] owner_dat;
    logic                  in_burst;
    logic                  accept;
    logic                  burst_end;

    // Search rr_ptr+1, rr_ptr+2, ... wrapping; the first valid requester wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!pick_vld && req_valid_i[cand[PTR_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        owner_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_dat = owner_dat | req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign owner_vld  = |(req_valid_i & grant_q);
    assign owner_last = |(req_last_i & grant_q);
    assign in_burst   = (state_q == ST_BURST);
    assign accept     = reset_n && in_burst && owner_vld && !fifo_full_i;
    assign burst_end  = accept && (owner_last || (beat_cnt_q == LAST_CNT));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == ST_IDLE) begin
            if (arb_en_i && pick_vld) begin
                state_d    = ST_BURST;
                grant_d    = GRANT_LSB << pick_idx;
                rr_ptr_d   = pick_idx;
                beat_cnt_d = '0;
            end
        end else if (burst_end) begin
            // Counter clears here, which is also where MAX_BURST=256 would wrap it.
            state_d    = ST_IDLE;
            grant_d    = '0;
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= PTR_RST;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign req_ready_o    = (reset_n && in_burst && !fifo_full_i) ? grant_q : '0;
    assign fifo_wr_en_o   = accept;
    assign fifo_wr_data_o = reset_n ? owner_dat : '0;
    assign grant_o        = grant_q;
    assign busy_o         = in_burst;
    assign beat_cnt_o     = beat_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester beat queues feed the DUT, a burst-level model
// predicts every output each cycle, and directed scenarios pin the model with literal expectations.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic             wr_clk = 1'b0;
    logic             reset_n;
    logic             arb_en_i;
    logic             fifo_full_i;
    logic [NR-1:0]    req_valid_i;
    logic [NR-1:0]    req_last_i;
    logic [NR*DW-1:0] req_data_i;
    logic [NR-1:0]    req_ready_o;
    logic [NR-1:0]    grant_o;
    logic             fifo_wr_en_o;
    logic [DW-1:0]    fifo_wr_data_o;
    logic             busy_o;
    logic [7:0]       beat_cnt_o;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wr_clk         (wr_clk),
        .reset_n        (reset_n),
        .arb_en_i       (arb_en_i),
        .req_valid_i    (req_valid_i),
        .req_last_i     (req_last_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .grant_o        (grant_o),
        .busy_o         (busy_o),
        .beat_cnt_o     (beat_cnt_o)
    );

    always #5 wr_clk = ~wr_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit k_rst = 1'b1, k_arb = 1'b1, k_full = 1'b0, rnd_gate = 1'b0;
    bit          hold  [NR];
    logic [DW:0] smem  [NR][256];
    int          shead [NR];
    int          stail [NR];
    logic [11:0] sseq  [NR];

    int m_owner = -1, m_cnt = 0, m_last = NR - 1, m_writes = 0, m_idx = 0, base_w = 0;
    bit m_done;
    int m_glog[$];
    int d_glog[$];
    logic [DW-1:0] d_wlog[$];
    int d_writes = 0;
    logic [NR-1:0] d_prev_grant = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit idle_all();
        if (m_owner >= 0) return 1'b0;
        for (int r = 0; r < NR; r++) if (stail[r] > shead[r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        reset_n     = !k_rst;
        arb_en_i    = k_arb;
        fifo_full_i = k_full;
        for (int r = 0; r < NR; r++) begin
            logic [DW:0] b;
            if (stail[r] > shead[r]) begin
                b = smem[r][shead[r] % 256];
                req_valid_i[r] = !hold[r] && (!rnd_gate || ($urandom_range(0, 3) != 0));
            end else begin
                b[DW-1:0] = DW'($urandom);
                b[DW]     = 1'($urandom);
                req_valid_i[r] = 1'b0;
            end
            req_last_i[r]          = b[DW];
            req_data_i[r*DW +: DW] = b[DW-1:0];
        end
    endtask

    task automatic tick();
        @(negedge wr_clk);
        drive();
        #3;
    endtask

    task automatic push_pkt(input int r, input logic [DW-1:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            smem[r][stail[r] % 256] = {(k == len - 1), base + DW'(k)};
            stail[r]++;
        end
    endtask

    task automatic do_reset();
        k_rst = 1'b1; k_full = 1'b0; k_arb = 1'b1; rnd_gate = 1'b0;
        tick();
        tick();
        for (int r = 0; r < NR; r++) begin
            stail[r] = shead[r];
            hold[r]  = 1'b0;
        end
        k_rst = 1'b0;
        m_glog.delete();
        d_glog.delete();
        d_wlog.delete();
        base_w = m_writes;
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while (n < budget && !idle_all()) begin
            tick();
            n++;
        end
        chk(nm, n < budget, 1);
        tick();
    endtask

    // Model: who owns the port and how many beats it has moved this burst.
    always @(posedge wr_clk) begin
        cyc++;
        if (!reset_n) begin
            m_owner = -1; m_cnt = 0; m_last = NR - 1;
        end else if (m_owner < 0) begin
            if (arb_en_i && req_valid_i != '0) begin
                for (int k = 1; k <= NR; k++) begin
                    m_idx = (m_last + k) % NR;
                    if (m_owner < 0 && req_valid_i[m_idx]) m_owner = m_idx;
                end
                m_last = m_owner;
                m_cnt  = 0;
                m_glog.push_back(m_owner);
            end
        end else if (req_valid_i[m_owner] && !fifo_full_i) begin
            m_done = req_last_i[m_owner] || (m_cnt + 1 == MB);
            shead[m_owner]++;
            m_writes++;
            m_cnt++;
            if (m_done) begin
                m_owner = -1; m_cnt = 0;
            end
        end
    end

    always @(negedge wr_clk) begin
        logic [NR-1:0] eg, er;
        logic          ew;
        logic [DW-1:0] ed;
        #2;
        eg = '0; er = '0; ew = 1'b0; ed = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            if (reset_n) begin
                ed = req_data_i[m_owner*DW +: DW];
                if (!fifo_full_i) begin
                    er[m_owner] = 1'b1;
                    ew = req_valid_i[m_owner];
                end
            end
        end
        chk("grant", grant_o, eg);
        chk("busy", busy_o, m_owner >= 0);
        chk("beat_cnt", beat_cnt_o, m_cnt);
        chk("ready", req_ready_o, er);
        chk("wr_en", fifo_wr_en_o, ew);
        chk("wr_data", fifo_wr_data_o, ed);
        if (fifo_wr_en_o === 1'b1) begin
            d_writes++;
            d_wlog.push_back(fifo_wr_data_o);
        end
        if (grant_o != '0 && d_prev_grant == '0) begin
            for (int i = 0; i < NR; i++) if (grant_o[i]) d_glog.push_back(i);
        end
        d_prev_grant = grant_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ord [5];
        int n, nf, stall, gap, blocked, j, rr, len, tot;
        logic [11:0] nseq [NR];

        for (int r = 0; r < NR; r++) begin
            shead[r] = 0; stail[r] = 0; hold[r] = 1'b0; sseq[r] = '0; nseq[r] = '0;
        end
        reset_n = 1'b0; arb_en_i = 1'b1; fifo_full_i = 1'b0;
        req_valid_i = '0; req_last_i = '0; req_data_i = '0;

        do_reset();
        chk("rst_grant", grant_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cnt", beat_cnt_o, 0);

        // Single requester, three beats.
        push_pkt(2, 16'h00A0, 3);
        tick();
        chk("t1_no_grant_yet", grant_o, 0);
        tick();
        chk("t1_grant", grant_o, 4'b0100);
        chk("t1_first_wr", fifo_wr_en_o, 1);
        drain("t1_drain", 20);
        chk("t1_nwr", d_wlog.size(), 3);
        for (int k = 0; k < 3; k++) chk("t1_data", (k < d_wlog.size()) ? d_wlog[k] : 16'hDEAD, 16'hA0 + k);
        chk("t1_grant_end", grant_o, 0);
        chk("t1_busy_end", busy_o, 0);

        // All requesters busy with 2-beat bursts: strict rotation.
        do_reset();
        for (int r = 0; r < NR; r++) begin
            push_pkt(r, DW'(16'h0100 * (r + 1)), 2);
            push_pkt(r, DW'(16'h0100 * (r + 1) + 16'h10), 2);
        end
        drain("t2_drain", 100);
        exp_ord = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            chk("t2_dut_order", (k < d_glog.size()) ? d_glog[k] : 99, exp_ord[k]);
            chk("t2_model_order", (k < m_glog.size()) ? m_glog[k] : 99, exp_ord[k]);
        end
        chk("t2_nwr", d_wlog.size(), 16);

        // Burst cap splits a long stream; the other requester gets a turn.
        do_reset();
        push_pkt(1, 16'h1000, 10);
        push_pkt(3, 16'h3000, 2);
        drain("t3_drain", 100);
        exp_ord = '{1, 3, 1, 1, 9};
        chk("t3_ngrants", d_glog.size(), 4);
        for (int k = 0; k < 4; k++) chk("t3_order", (k < d_glog.size()) ? d_glog[k] : 99, exp_ord[k]);
        chk("t3_nwr", d_wlog.size(), 12);
        j = 0;
        for (int k = 0; k < d_wlog.size(); k++) begin
            if (d_wlog[k][15:12] == 4'h1) begin
                chk("t3_req1_order", d_wlog[k], 16'h1000 + j);
                j++;
            end
        end
        chk("t3_req1_count", j, 10);

        // FIFO full for 5 cycles after beat 2.
        do_reset();
        push_pkt(0, 16'h0400, 6);
        nf = 0; stall = 0;
        for (int c = 0; c < 40; c++) begin
            k_full = (m_writes - base_w >= 2) && (nf < 5);
            tick();
            if (fifo_full_i) begin
                nf++;
                if (grant_o == 4'b0001 && req_ready_o == '0 && !fifo_wr_en_o) stall++;
            end
        end
        k_full = 1'b0;
        drain("t4_drain", 20);
        chk("t4_full_cycles", nf, 5);
        chk("t4_stalls", stall, 5);
        chk("t4_nwr", d_wlog.size(), 6);
        for (int k = 0; k < 6; k++) chk("t4_data", (k < d_wlog.size()) ? d_wlog[k] : 16'hDEAD, 16'h0400 + k);

        // Owner bubble holds the grant; arb_en low in IDLE blocks the next grant.
        do_reset();
        push_pkt(0, 16'h0500, 4);
        push_pkt(1, 16'h0600, 2);
        n = 0;
        while (m_writes - base_w < 1 && n < 20) begin tick(); n++; end
        chk("t5_first_beat", n < 20, 1);
        hold[0] = 1'b1;
        gap = 0;
        repeat (3) begin
            tick();
            if (grant_o == 4'b0001 && !fifo_wr_en_o && req_valid_i[1]) gap++;
        end
        chk("t5_gap", gap, 3);
        hold[0] = 1'b0;
        k_arb = 1'b0;
        n = 0;
        while (m_owner >= 0 && n < 20) begin tick(); n++; end
        chk("t5_burst_done", n < 20, 1);
        blocked = 0;
        repeat (5) begin
            tick();
            if (grant_o == '0 && req_valid_i[1]) blocked++;
        end
        chk("t5_arb_blocked", blocked, 5);
        k_arb = 1'b1;
        tick();
        chk("t5_regrant_wait", grant_o, 0);
        tick();
        chk("t5_regrant", grant_o, 4'b0010);
        drain("t5_drain", 30);

        // Reset in the middle of a burst; arbitration restarts at requester 0.
        do_reset();
        push_pkt(0, 16'h0700, 4);
        push_pkt(3, 16'h3700, 1);
        n = 0;
        while (m_writes - base_w < 1 && n < 20) begin tick(); n++; end
        chk("t6_first_beat", n < 20, 1);
        k_rst = 1'b1;
        tick();
        chk("t6_rst_wr", fifo_wr_en_o, 0);
        chk("t6_rst_rdy", req_ready_o, 0);
        k_rst = 1'b0;
        tick();
        chk("t6_after_grant", grant_o, 0);
        chk("t6_after_wr", fifo_wr_en_o, 0);
        tick();
        chk("t6_restart", grant_o, 4'b0001);
        drain("t6_drain", 30);

        // Random traffic, full, arb_en and occasional reset.
        do_reset();
        rnd_gate = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            for (int r = 0; r < NR; r++) begin
                if ($urandom_range(0, 7) == 0 && stail[r] - shead[r] < 150) begin
                    len = $urandom_range(1, 7);
                    for (int k = 0; k < len; k++) begin
                        smem[r][stail[r] % 256] = {(k == len - 1), 4'(r), sseq[r]};
                        stail[r]++;
                        sseq[r]++;
                    end
                end
            end
            k_full = ($urandom_range(0, 4) == 0);
            k_arb  = ($urandom_range(0, 7) != 0);
            k_rst  = ($urandom_range(0, 399) == 0);
            tick();
        end
        rnd_gate = 1'b0; k_full = 1'b0; k_arb = 1'b1; k_rst = 1'b0;
        drain("rand_drain", 3000);
        for (int k = 0; k < d_wlog.size(); k++) begin
            rr = int'(d_wlog[k][15:12]) % NR;
            chk("rand_order", d_wlog[k][11:0], nseq[rr]);
            nseq[rr]++;
        end
        tot = 0;
        for (int r = 0; r < NR; r++) tot += int'(sseq[r]);
        chk("rand_count", d_wlog.size(), tot);
        chk("total_writes", d_writes, m_writes);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's FIFO (`asys_fifo`) between NUM_REQ requesters.
- Arbitration is round-robin and per burst: the winner owns the port until it sends its `last` beat or reaches MAX_BURST beats.
- Sits in the wr_clk domain, directly in front of the FIFO's wr_en_i/wr_data_i. It watches the FIFO full indication so that no beat is ever dropped.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, beat width; must match the FIFO.
- MAX_BURST, 16, maximum beats per grant (1..256).

Ports:
- wr_clk  input  1  clock; all logic is rising-edge.
- reset_n  input  1  reset: synchronous, active-low; clock wr_clk.
- arb_en_i  input  1  when low, no new grant is issued; a burst in progress runs to completion.
- req_valid_i  input  NUM_REQ  per-requester beat valid.
- req_last_i  input  NUM_REQ  per-requester end-of-burst marker, qualified by valid.
- req_data_i  input  NUM_REQ*DATA_WIDTH  flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  output  NUM_REQ  combinational beat-accept, one-hot or zero.
- fifo_full_i  input  1  current-cycle FIFO full (the unregistered full term that gates the FIFO's internal write).
- fifo_wr_en_o  output  1  write strobe to the FIFO.
- fifo_wr_data_o  output  DATA_WIDTH  write data to the FIFO.
- grant_o  output  NUM_REQ  registered one-hot current owner; zero when idle.
- busy_o  output  1  high while in BURST state.
- beat_cnt_o  output  8  number of beats accepted in the current burst.

Behaviour:
- Reset (reset_n=0 at a wr_clk edge):
  - state=IDLE, grant_o=0, busy_o=0, beat_cnt_o=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has highest priority after reset.
  - req_ready_o, fifo_wr_en_o and fifo_wr_data_o are forced to 0 while reset_n=0.
- States:
  - IDLE: no owner. If arb_en_i=1 and |req_valid_i, pick the first i with req_valid_i[i]=1, searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - On that pick: grant_o<=onehot(i), rr_ptr<=i, beat_cnt<=0, state<=BURST.
  - The grant is registered, so the first beat is accepted no earlier than the cycle after the request is seen (1-cycle arbitration latency).
  - BURST, owner o: accept = req_valid_i[o] & ~fifo_full_i.
    - req_ready_o[o] = ~fifo_full_i. All other ready bits are 0.
    - fifo_wr_en_o = accept. fifo_wr_data_o = owner slice of req_data_i (mux on grant_o, purely combinational).
  - On accept: beat_cnt<=beat_cnt+1.
  - Burst end = accept & (req_last_i[o] | beat_cnt==MAX_BURST-1). At burst end: state<=IDLE, grant_o<=0, beat_cnt<=0.
- There is always exactly one IDLE cycle between bursts. Back-to-back bursts therefore take 1 dead cycle; this is accepted.
- Owner drops valid mid-burst: the grant is held indefinitely and no other requester is serviced. Bubble cycles have fifo_wr_en_o=0.
- FIFO full: no write is issued while fifo_full_i=1. The owner's ready is low, the beat stalls, and the grant is held. No beat is ever lost or duplicated.
- MAX_BURST reached without last: the grant ends. The requester's remaining beats compete in the next arbitration like any new request.
- arb_en_i low during BURST has no effect. arb_en_i low in IDLE blocks the grant decision.
- Only valid beats of the owner are observed. Non-owner valid/last/data are ignored and need not be stable.
- fifo_wr_en_o and req_ready_o[o] with req_valid_i[o] form the same handshake: ready & valid ⇔ FIFO write.
- Reset mid-burst: everything returns to IDLE with no write in the reset cycle. Partial burst data already in the FIFO stays there.
- beat_cnt width is 8 bits. With MAX_BURST=256 it wraps to 0 exactly at burst end.

Test Plan:
- Single requester, NUM_REQ=4: req 2 sends 3 beats 0xA0..0xA2, last on the third. Expect grant_o=4'b0100 one cycle after valid, fifo_wr_en_o high for 3 consecutive cycles with data 0xA0,0xA1,0xA2, then grant_o=0 and busy_o=0.
- All 4 requesters continuously valid, each burst 2 beats, after reset. Expect grant order 0,1,2,3,0, each grant yielding exactly 2 writes, with 1 idle cycle between grants.
- MAX_BURST=4: req 1 streams 10 beats with no last while req 3 is also valid. Expect 4 beats from req 1, then grant to req 3, then req 1 again. No beat is lost; FIFO contents are in order per requester.
- fifo_full_i high for 5 cycles mid-burst (after beat 2 of 6). Expect req_ready_o=0 and fifo_wr_en_o=0 for those 5 cycles, grant held, beats 3..6 written after full drops; total writes = 6.
- Owner req 0 drops valid for 3 cycles mid-burst while req 1 is valid. Expect grant_o stays 4'b0001 and there are no writes during the gap. arb_en_i=0 in IDLE with req 1 valid: expect no grant until arb_en_i returns to 1.
- reset_n pulsed low during beat 2 of a 4-beat burst. Expect fifo_wr_en_o=0 and grant_o=0 the cycle after. The next arbitration starts from requester 0.
